aemb_wb_arbiter: RTL and testbench
==================================

// Module: aemb_wb_arbiter
// PURPOSE
//  Two-master WISHBONE arbiter that shares one memory port between the aeMB instruction bus (iwb)
//  and data bus (dwb). Sits between the core and a unified single-port memory or slave fabric.
//  Data accesses have priority. A fairness counter stops instruction fetch from starving.
//  A watchdog terminates transfers that the slave never acknowledges.
// PARAMETERS
//  AW    30  address width; addresses are word addresses [AW+1:2]
//  FAIR  4   max consecutive dwb grants while iwb waits (1..15)
//  TMO   255 watchdog cycles before forced termination (1..255); 0 = watchdog disabled
// PORTS
//  sys_clk_i   in   1      clock; all logic on the rising edge
//  sys_rst_i   in   1      synchronous reset, active-low
//  iwb_stb_i   in   1      instruction request
//  iwb_adr_i   in   AW     instruction word address
//  iwb_ack_o   out  1      instruction acknowledge
//  iwb_dat_o   out  32     instruction read data
//  dwb_stb_i   in   1      data request
//  dwb_wre_i   in   1      data write enable
//  dwb_sel_i   in   4      data byte selects
//  dwb_adr_i   in   AW     data word address
//  dwb_dat_i   in   32     data write data
//  dwb_ack_o   out  1      data acknowledge
//  dwb_dat_o   out  32     data read data
//  mwb_stb_o   out  1      shared-port strobe
//  mwb_wre_o   out  1      shared-port write enable; 0 for instruction grants
//  mwb_sel_o   out  4      shared-port byte selects; 4'hF for instruction grants
//  mwb_adr_o   out  AW     shared-port address
//  mwb_dat_o   out  32     shared-port write data
//  mwb_dat_i   in   32     shared-port read data
//  mwb_ack_i   in   1      shared-port acknowledge
//  err_o       out  1      sticky flag: a watchdog timeout has occurred
// BEHAVIOUR
//  - FSM states: IDLE, GNT_I, GNT_D. On reset: state=IDLE, fair count=0, watchdog=0, err_o=0.
//    In IDLE, all mwb_* outputs and both acks are 0.
//  - Arbitration function ARB, evaluated in IDLE and on every terminating cycle:
//    - dwb_stb_i & (!iwb_stb_i | dcnt<FAIR) -> GNT_D
//    - else iwb_stb_i -> GNT_I
//    - else -> IDLE
//  - Grant latency: the grant is registered, so mwb_stb_o rises 1 cycle after the request enters IDLE.
//  - In GNT_x, mwb_* are a combinational mux of the granted master's inputs;
//    mwb_stb_o = granted master's stb_i.
//  - Acks and read data:
//    - granted ack_o = mwb_ack_i (same cycle); the other ack_o stays 0.
//    - iwb_dat_o and dwb_dat_o both carry mwb_dat_i; only the qualified ack is meaningful.
//  - Termination: on mwb_ack_i, next state = ARB on current inputs.
//    Back-to-back grants to the same master keep mwb_stb_o high with no bubble.
//  - Abort: if the granted stb_i drops before ack -> IDLE next cycle. No ack; dcnt unchanged.
//  - Fairness counter dcnt (4 bits, saturating):
//    - +1 on each GNT_D entry while iwb_stb_i=1
//    - cleared on each GNT_I entry, or on a dwb grant with iwb_stb_i=0
//  - Watchdog counter:
//    - cleared on every grant entry (including re-grants)
//    - increments each GNT_x cycle without mwb_ack_i
//    - when it reaches TMO-1 with no ack: pulse the granted ack_o for 1 cycle with dat_o=32'h0,
//      set err_o, next state = IDLE
//  - mwb_ack_i on the timeout cycle: the real ack wins; err_o is not set.
//  - mwb_ack_i in IDLE, or for a non-granted master, is ignored.
//  - err_o is cleared only by reset.
//  - Reset mid-transfer: next edge forces IDLE; mwb_stb_o=0; counters and err_o cleared;
//    the pending transfer is dropped without ack.
// TESTING
//  - Single iwb read: iwb_stb_i=1, adr=0x10; slave acks 2 cycles after stb with 0xA5A5A5A5
//    -> mwb_stb_o at cycle 1, iwb_ack_o=1 with dat=0xA5A5A5A5 at cycle 3, mwb_wre_o=0, sel=F.
//  - Simultaneous iwb+dwb requests, zero-wait slave, FAIR=4
//    -> grant sequence D,D,D,D,I,D,D,D,D,I; dcnt resets after each I grant.
//  - dwb write, sel=4'b0011, dat=0x12345678
//    -> mwb_wre_o=1, mwb_sel_o=3, mwb_dat_o=0x12345678; dwb_ack_o on mwb_ack_i; iwb_ack_o=0 throughout.
//  - Slave never acks, TMO=8 -> granted ack pulses at the 8th GNT cycle, dat=0, err_o=1 and stays set;
//    ack arriving exactly at cycle 8 -> normal ack, err_o=0.
//  - dwb_stb_i dropped 1 cycle into GNT_D with iwb pending
//    -> IDLE, no dwb_ack_o, then GNT_I on the following cycle.
//  - sys_rst_i=0 asserted mid-GNT_D -> mwb_stb_o=0 next edge, err_o=0;
//    after release, an iwb-only request is granted normally.

Source files
------------

// File: rtl/aemb_wb_arbiter.sv
// Two-master WISHBONE arbiter: aeMB data bus (priority) and instruction bus share one slave port.
// A fairness counter bounds data-bus monopoly, and a watchdog terminates unacknowledged transfers.
module aemb_wb_arbiter #(
    parameter int AW   = 30,
    parameter int FAIR = 4,
    parameter int TMO  = 255
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          iwb_stb_i,
    input  logic [AW-1:0] iwb_adr_i,
    output logic          iwb_ack_o,
    output logic [31:0]   iwb_dat_o,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic          dwb_ack_o,
    output logic [31:0]   dwb_dat_o,
    output logic          mwb_stb_o,
    output logic          mwb_wre_o,
    output logic [3:0]    mwb_sel_o,
    output logic [AW-1:0] mwb_adr_o,
    output logic [31:0]   mwb_dat_o,
    input  logic [31:0]   mwb_dat_i,
    input  logic          mwb_ack_i,
    output logic          err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    localparam logic [3:0] FAIR_C   = 4'(FAIR);
    localparam bit         WDOG_EN  = (TMO != 0);
    localparam logic [7:0] TMO_LAST = (TMO == 0) ? 8'd0 : 8'(TMO - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;

    logic [1:0] arb_s;
    logic       granted_s;
    logic       gnt_stb_s;
    logic       expire_s;
    logic       timeout_s;
    logic       enter_s;

    // Arbitration decision on current requests and fairness count
    always_comb begin
        if (dwb_stb_i && (!iwb_stb_i || (dcnt_q < FAIR_C))) begin
            arb_s = ST_GNT_D;
        end else if (iwb_stb_i) begin
            arb_s = ST_GNT_I;
        end else begin
            arb_s = ST_IDLE;
        end
    end

    assign granted_s = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);
    assign gnt_stb_s = (state_q == ST_GNT_D) ? dwb_stb_i :
                       (state_q == ST_GNT_I) ? iwb_stb_i : 1'b0;
    assign expire_s  = WDOG_EN && (wdog_q == TMO_LAST);
    // A real ack on the expiry cycle wins; an abandoned strobe is an abort, not a timeout.
    assign timeout_s = granted_s && gnt_stb_s && !mwb_ack_i && expire_s;

    // Next-state, fairness and watchdog logic
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        enter_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                enter_s = 1'b1;
            end
            ST_GNT_I, ST_GNT_D: begin
                if (mwb_ack_i) begin
                    enter_s = 1'b1;
                end else if (!gnt_stb_s) begin
                    state_d = ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_s) begin
            state_d = arb_s;
            wdog_d  = 8'd0;
            if (arb_s == ST_GNT_D) begin
                if (iwb_stb_i) begin
                    dcnt_d = (dcnt_q == 4'hF) ? 4'hF : dcnt_q + 4'd1;
                end else begin
                    dcnt_d = 4'd0;
                end
            end else if (arb_s == ST_GNT_I) begin
                dcnt_d = 4'd0;
            end else begin
                dcnt_d = dcnt_q;
            end
        end else begin
            state_d = state_d;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state_q <= ST_IDLE;
            dcnt_q  <= 4'd0;
            wdog_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    // Shared-port mux and acknowledge routing
    always_comb begin
        mwb_stb_o = 1'b0;
        mwb_wre_o = 1'b0;
        mwb_sel_o = 4'h0;
        mwb_adr_o = '0;
        mwb_dat_o = 32'h0;
        case (state_q)
            ST_GNT_I: begin
                mwb_stb_o = iwb_stb_i;
                mwb_wre_o = 1'b0;
                mwb_sel_o = 4'hF;
                mwb_adr_o = iwb_adr_i;
                mwb_dat_o = 32'h0;
            end
            ST_GNT_D: begin
                mwb_stb_o = dwb_stb_i;
                mwb_wre_o = dwb_wre_i;
                mwb_sel_o = dwb_sel_i;
                mwb_adr_o = dwb_adr_i;
                mwb_dat_o = dwb_dat_i;
            end
            default: begin
                mwb_stb_o = 1'b0;
            end
        endcase
    end

    assign iwb_ack_o = (state_q == ST_GNT_I) && (mwb_ack_i || timeout_s);
    assign dwb_ack_o = (state_q == ST_GNT_D) && (mwb_ack_i || timeout_s);
    assign iwb_dat_o = timeout_s ? 32'h0 : mwb_dat_i;
    assign dwb_dat_o = timeout_s ? 32'h0 : mwb_dat_i;
    assign err_o     = err_q;

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// Directed bench for aemb_wb_arbiter (FAIR=4, TMO=8) with an acknowledge scoreboard.
module tb_aemb_wb_arbiter;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iwb_stb, dwb_stb, dwb_wre, mwb_ack;
    logic [AW-1:0] iwb_adr, dwb_adr;
    logic [3:0]    dwb_sel;
    logic [31:0]   dwb_dat, mwb_dat_in;
    logic          iwb_ack, dwb_ack, mwb_stb, mwb_wre, err;
    logic [31:0]   iwb_dat, dwb_dat_out, mwb_dat_out;
    logic [3:0]    mwb_sel;
    logic [AW-1:0] mwb_adr;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    aemb_wb_arbiter #(.AW(AW), .FAIR(4), .TMO(8)) dut (
        .sys_clk_i(clk),     .sys_rst_i(rst_n),
        .iwb_stb_i(iwb_stb), .iwb_adr_i(iwb_adr), .iwb_ack_o(iwb_ack), .iwb_dat_o(iwb_dat),
        .dwb_stb_i(dwb_stb), .dwb_wre_i(dwb_wre), .dwb_sel_i(dwb_sel), .dwb_adr_i(dwb_adr),
        .dwb_dat_i(dwb_dat), .dwb_ack_o(dwb_ack), .dwb_dat_o(dwb_dat_out),
        .mwb_stb_o(mwb_stb), .mwb_wre_o(mwb_wre), .mwb_sel_o(mwb_sel), .mwb_adr_o(mwb_adr),
        .mwb_dat_o(mwb_dat_out), .mwb_dat_i(mwb_dat_in), .mwb_ack_i(mwb_ack), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed and sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Pop the oldest expected acknowledge and compare it with what the DUT presents now.
    task automatic pop_ack(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_iack"}, {31'd0, iwb_ack}, {31'd0, !e.is_d});
            chk({tag, "_dack"}, {31'd0, dwb_ack}, {31'd0, e.is_d});
            chk({tag, "_dat"}, e.is_d ? dwb_dat_out : iwb_dat, e.dat);
        end
    endtask

    task automatic drain(input string tag);
        iwb_stb = 1'b0;
        dwb_stb = 1'b0;
        dwb_wre = 1'b0;
        mwb_ack = 1'b0;
        tick();
        tick();
        settle();
        chk({tag, "_idle_stb"}, {31'd0, mwb_stb}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        iwb_stb = 1'b0; iwb_adr = '0;
        dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_sel = 4'h0; dwb_adr = '0; dwb_dat = 32'h0;
        mwb_ack = 1'b0; mwb_dat_in = 32'h0;
        tick();
        tick();
        settle();
        chk("rst_stb", {31'd0, mwb_stb}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_acks", {30'd0, iwb_ack, dwb_ack}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single instruction read, slave acks two cycles after the strobe appears
        iwb_stb = 1'b1; iwb_adr = 30'h10;
        settle();
        chk("t1_c0_stb", {31'd0, mwb_stb}, 32'd0);
        sb.push_back('{is_d: 1'b0, dat: 32'hA5A5A5A5});
        tick(); settle();
        chk("t1_c1_stb", {31'd0, mwb_stb}, 32'd1);
        chk("t1_wre", {31'd0, mwb_wre}, 32'd0);
        chk("t1_sel", {28'd0, mwb_sel}, 32'hF);
        chk("t1_adr", {2'd0, mwb_adr}, 32'h10);
        chk("t1_c1_ack", {31'd0, iwb_ack}, 32'd0);
        tick(); settle();
        chk("t1_c2_ack", {31'd0, iwb_ack}, 32'd0);
        tick();
        mwb_ack = 1'b1; mwb_dat_in = 32'hA5A5A5A5;
        settle();
        pop_ack("t1_c3");
        drain("t1");

        // Both masters requesting, zero-wait slave: D,D,D,D,I,D,D,D,D,I
        iwb_stb = 1'b1; iwb_adr = 30'h100;
        dwb_stb = 1'b1; dwb_adr = 30'h200; dwb_sel = 4'hF;
        mwb_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sb.push_back('{is_d: !((k == 4) || (k == 9)), dat: 32'hC0DE0000 + 32'(k)});
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            mwb_dat_in = 32'hC0DE0000 + 32'(k);
            settle();
            pop_ack($sformatf("t2_g%0d", k));
            tick();
        end
        drain("t2");

        // Data write carries write enable, byte selects and data to the shared port
        dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_sel = 4'b0011; dwb_adr = 30'h20; dwb_dat = 32'h12345678;
        mwb_dat_in = 32'h0;
        tick(); settle();
        chk("t3_wre", {31'd0, mwb_wre}, 32'd1);
        chk("t3_sel", {28'd0, mwb_sel}, 32'h3);
        chk("t3_dat", mwb_dat_out, 32'h12345678);
        chk("t3_adr", {2'd0, mwb_adr}, 32'h20);
        chk("t3_noack", {30'd0, iwb_ack, dwb_ack}, 32'd0);
        sb.push_back('{is_d: 1'b1, dat: 32'h0});
        tick();
        mwb_ack = 1'b1;
        settle();
        pop_ack("t3");
        drain("t3");

        // Real ack on the 8th granted cycle beats the watchdog
        dwb_stb = 1'b1; dwb_sel = 4'hF; mwb_dat_in = 32'h600DF00D;
        tick();
        for (int c = 1; c < 8; c++) begin
            settle();
            chk($sformatf("t4a_c%0d_ack", c), {31'd0, dwb_ack}, 32'd0);
            tick();
        end
        mwb_ack = 1'b1;
        sb.push_back('{is_d: 1'b1, dat: 32'h600DF00D});
        settle();
        pop_ack("t4a_c8");
        dwb_stb = 1'b0;
        tick(); settle();
        chk("t4a_err", {31'd0, err}, 32'd0);
        drain("t4a");

        // Slave never acks: forced ack with zero data on the 8th cycle, sticky error
        dwb_stb = 1'b1; mwb_dat_in = 32'hFFFFFFFF;
        tick();
        for (int c = 1; c < 8; c++) begin
            settle();
            chk($sformatf("t4b_c%0d_ack", c), {31'd0, dwb_ack}, 32'd0);
            tick();
        end
        sb.push_back('{is_d: 1'b1, dat: 32'h0});
        settle();
        pop_ack("t4b_c8");
        tick(); settle();
        chk("t4b_c9_stb", {31'd0, mwb_stb}, 32'd0);
        chk("t4b_c9_err", {31'd0, err}, 32'd1);
        drain("t4b");
        chk("t4b_err_sticky", {31'd0, err}, 32'd1);

        // Data master abandons its request with an instruction fetch waiting
        dwb_stb = 1'b1; iwb_stb = 1'b1; iwb_adr = 30'h3C;
        tick(); settle();
        chk("t5_gnt_d", {31'd0, mwb_wre | (mwb_adr == 30'h20 ? 1'b0 : 1'b1)}, 32'd0);
        dwb_stb = 1'b0;
        settle();
        chk("t5_drop_ack", {30'd0, iwb_ack, dwb_ack}, 32'd0);
        tick(); settle();
        chk("t5_idle_stb", {31'd0, mwb_stb}, 32'd0);
        chk("t5_idle_ack", {30'd0, iwb_ack, dwb_ack}, 32'd0);
        tick(); settle();
        chk("t5_gnt_i_stb", {31'd0, mwb_stb}, 32'd1);
        chk("t5_gnt_i_adr", {2'd0, mwb_adr}, 32'h3C);
        chk("t5_gnt_i_sel", {28'd0, mwb_sel}, 32'hF);
        drain("t5");

        // Reset in the middle of a data grant
        dwb_stb = 1'b1; dwb_adr = 30'h55;
        tick(); settle();
        chk("t6_pre_stb", {31'd0, mwb_stb}, 32'd1);
        rst_n = 1'b0;
        tick(); settle();
        chk("t6_rst_stb", {31'd0, mwb_stb}, 32'd0);
        chk("t6_rst_err", {31'd0, err}, 32'd0);
        chk("t6_rst_ack", {30'd0, iwb_ack, dwb_ack}, 32'd0);
        rst_n = 1'b1; dwb_stb = 1'b0;
        iwb_stb = 1'b1; iwb_adr = 30'h44; mwb_dat_in = 32'h5A5A5A5A;
        tick(); settle();
        chk("t6_gnt_stb", {31'd0, mwb_stb}, 32'd1);
        chk("t6_gnt_adr", {2'd0, mwb_adr}, 32'h44);
        sb.push_back('{is_d: 1'b0, dat: 32'h5A5A5A5A});
        mwb_ack = 1'b1;
        settle();
        pop_ack("t6");
        drain("t6");
        chk("sb_leftover", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
